// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALUOp encodings and the control bundle
// carried from decode into the ID/EX register.
package riscv_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_SR     = 3'b101;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    branch;
        logic    memRead;
        logic    memToReg;
        logic    memWrite;
        logic    ALUSrc;
        logic    regWrite;
        logic    jump;
        alu_op_e ALUOp;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate former; the sign bit is always instr[31].
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_uImm;

    assign w_uImm = {i_instr[31:12], 12'b0};

    always_comb begin
        o_imm = '0;
        case (i_instr[6:0])
            OPC_LD, OPC_IMM, OPC_JALR:
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            OPC_S:
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            OPC_B:
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
            OPC_JAL:
                o_imm = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
            OPC_LUI, OPC_AUIPC:
                o_imm = {{(XLEN-31){i_instr[31]}}, w_uImm[30:0]};
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode plus ID/EX pipeline register, with load-use bubble insertion,
// EX flush and EX backpressure handling.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int HAZARD_EN        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [31:0]                 in_instr,
    input  logic [XLEN-1:0]             in_pc,
    input  logic                        flush,
    input  logic                        ex_ready,
    output logic                        id_stall,
    output logic                        out_valid,
    output logic [XLEN-1:0]             out_pc,
    output logic [XLEN-1:0]             out_imm,
    output logic [REG_NUM_BITWIDTH-1:0] out_rs1,
    output logic [REG_NUM_BITWIDTH-1:0] out_rs2,
    output logic [REG_NUM_BITWIDTH-1:0] out_rd,
    output logic                        out_branch,
    output logic                        out_memRead,
    output logic                        out_memToReg,
    output logic                        out_memWrite,
    output logic                        out_ALUSrc,
    output logic                        out_regWrite,
    output logic                        out_jump,
    output logic [1:0]                  out_ALUOp,
    output logic [3:0]                  out_inst_ALU,
    output logic                        out_illegal
);

    logic [XLEN-1:0]             w_imm;
    logic [REG_NUM_BITWIDTH-1:0] w_rs1, w_rs2, w_rd;
    logic [3:0]                  w_instAlu;
    ctrl_t                       w_ctrl;
    logic                        w_useRs1, w_useRs2, w_hazard;

    logic                        r_valid;
    logic [XLEN-1:0]             r_pc, r_imm;
    logic [REG_NUM_BITWIDTH-1:0] r_rs1, r_rs2, r_rd;
    logic [3:0]                  r_instAlu;
    ctrl_t                       r_ctrl;

    imm_gen #(.XLEN(XLEN)) u_immGen (
        .i_instr (in_instr),
        .o_imm   (w_imm)
    );

    assign w_rs1 = REG_NUM_BITWIDTH'(in_instr[19:15]);
    assign w_rs2 = REG_NUM_BITWIDTH'(in_instr[24:20]);
    assign w_rd  = REG_NUM_BITWIDTH'(in_instr[11:7]);

    always_comb begin
        w_ctrl    = '0;
        w_useRs1  = 1'b0;
        w_useRs2  = 1'b0;
        w_instAlu = {in_instr[30], in_instr[14:12]};
        case (in_instr[6:0])
            OPC_R: begin
                w_ctrl.regWrite = 1'b1;
                w_ctrl.ALUOp    = ALUOP_RTYPE;
                w_useRs1        = 1'b1;
                w_useRs2        = 1'b1;
            end
            OPC_LD: begin
                w_ctrl.memRead  = 1'b1;
                w_ctrl.memToReg = 1'b1;
                w_ctrl.ALUSrc   = 1'b1;
                w_ctrl.regWrite = 1'b1;
                w_useRs1        = 1'b1;
            end
            OPC_IMM: begin
                w_ctrl.ALUSrc   = 1'b1;
                w_ctrl.regWrite = 1'b1;
                w_ctrl.ALUOp    = ALUOP_ITYPE;
                w_useRs1        = 1'b1;
                // instr[30] is immediate data except for the SRLI/SRAI selector
                if (in_instr[14:12] != F3_SR)
                    w_instAlu[3] = 1'b0;
            end
            OPC_S: begin
                w_ctrl.memWrite = 1'b1;
                w_ctrl.ALUSrc   = 1'b1;
                w_useRs1        = 1'b1;
                w_useRs2        = 1'b1;
            end
            OPC_B: begin
                w_ctrl.branch   = 1'b1;
                w_ctrl.ALUOp    = ALUOP_BRANCH;
                w_useRs1        = 1'b1;
                w_useRs2        = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.jump     = 1'b1;
                w_ctrl.regWrite = 1'b1;
            end
            OPC_JALR: begin
                w_ctrl.jump     = 1'b1;
                w_ctrl.regWrite = 1'b1;
                w_ctrl.ALUSrc   = 1'b1;
                w_useRs1        = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_ctrl.ALUSrc   = 1'b1;
                w_ctrl.regWrite = 1'b1;
            end
            default: w_ctrl.illegal = 1'b1;
        endcase
    end

    // A bubble or flush entry carries memRead=0, so it can never cause a hazard.
    assign w_hazard = (HAZARD_EN != 0) && in_valid && r_valid && r_ctrl.memRead &&
                      (r_rd != '0) &&
                      ((w_useRs1 && (r_rd == w_rs1)) || (w_useRs2 && (r_rd == w_rs2)));

    always_comb begin
        id_stall = 1'b0;
        if (rst || flush)
            id_stall = 1'b0;
        else if (!ex_ready)
            id_stall = in_valid;
        else if (w_hazard)
            id_stall = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_instAlu <= '0;
            r_ctrl    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (ex_ready) begin
            r_pc      <= in_pc;
            r_imm     <= w_imm;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_instAlu <= w_instAlu;
            if (w_hazard) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else begin
                r_valid <= in_valid;
                r_ctrl  <= in_valid ? w_ctrl : '0;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_imm      = r_imm;
    assign out_rs1      = r_rs1;
    assign out_rs2      = r_rs2;
    assign out_rd       = r_rd;
    assign out_inst_ALU = r_instAlu;
    assign out_branch   = r_ctrl.branch;
    assign out_memRead  = r_ctrl.memRead;
    assign out_memToReg = r_ctrl.memToReg;
    assign out_memWrite = r_ctrl.memWrite;
    assign out_ALUSrc   = r_ctrl.ALUSrc;
    assign out_regWrite = r_ctrl.regWrite;
    assign out_jump     = r_ctrl.jump;
    assign out_ALUOp    = r_ctrl.ALUOp;
    assign out_illegal  = r_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: each step queues the ID/EX entry it should produce
// and checks it one clock later, alongside the combinational id_stall.
module tb_id_ex_stage;

    typedef struct {
        logic        valid;
        logic [9:0]  ctrl;
        logic        chk;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
    } exp_t;

    // ctrl order: branch memRead memToReg memWrite ALUSrc regWrite jump ALUOp[1:0] illegal
    localparam logic [9:0] C_NONE = 10'b0000000000;
    localparam logic [9:0] C_IMM  = 10'b0000110110;
    localparam logic [9:0] C_UPP  = 10'b0000110000;
    localparam logic [9:0] C_JAL  = 10'b0000011000;
    localparam logic [9:0] C_BR   = 10'b1000000010;
    localparam logic [9:0] C_LD   = 10'b0110110000;
    localparam logic [9:0] C_R    = 10'b0000010100;
    localparam logic [9:0] C_ST   = 10'b0001100000;
    localparam logic [9:0] C_ILL  = 10'b0000000001;

    localparam logic [31:0] I_ADDI  = 32'hFFF00093;
    localparam logic [31:0] I_LUI   = 32'h12345137;
    localparam logic [31:0] I_JAL   = 32'hFFDFF0EF;
    localparam logic [31:0] I_BEQ   = 32'hFE208CE3;
    localparam logic [31:0] I_SRAI  = 32'h4040D193;
    localparam logic [31:0] I_LW5   = 32'h0000A283;
    localparam logic [31:0] I_ADD   = 32'h00228333;
    localparam logic [31:0] I_LW0   = 32'h0000A003;
    localparam logic [31:0] I_ADD00 = 32'h00000333;
    localparam logic [31:0] I_SW    = 32'h0072A023;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, ex_ready;
    logic [31:0] in_instr, in_pc;
    logic        id_stall, out_valid;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_branch, out_memRead, out_memToReg, out_memWrite;
    logic        out_ALUSrc, out_regWrite, out_jump, out_illegal;
    logic [1:0]  out_ALUOp;
    logic [3:0]  out_inst_ALU;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .ex_ready(ex_ready), .id_stall(id_stall), .out_valid(out_valid),
        .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_branch(out_branch), .out_memRead(out_memRead),
        .out_memToReg(out_memToReg), .out_memWrite(out_memWrite), .out_ALUSrc(out_ALUSrc),
        .out_regWrite(out_regWrite), .out_jump(out_jump), .out_ALUOp(out_ALUOp),
        .out_inst_ALU(out_inst_ALU), .out_illegal(out_illegal)
    );

    function automatic exp_t mk(logic v, logic [9:0] c, logic chk, logic [31:0] pc,
                                logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [3:0] alu);
        exp_t e;
        e.valid = v; e.ctrl = c; e.chk = chk; e.pc = pc; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.alu = alu;
        return e;
    endfunction

    function automatic exp_t bubble();
        return mk(1'b0, C_NONE, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pops the oldest queued entry and compares it with what the ID/EX register holds.
    task automatic checkOutput(input string tag);
        exp_t e;
        checks++;
        assert (expQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal({tag, "_valid"}, 32'(out_valid), 32'(e.valid));
            checkVal({tag, "_ctrl"}, 32'({out_branch, out_memRead, out_memToReg, out_memWrite,
                     out_ALUSrc, out_regWrite, out_jump, out_ALUOp, out_illegal}), 32'(e.ctrl));
            if (e.chk) begin
                checkVal({tag, "_pc"}, out_pc, e.pc);
                checkVal({tag, "_imm"}, out_imm, e.imm);
                checkVal({tag, "_rs1"}, 32'(out_rs1), 32'(e.rs1));
                checkVal({tag, "_rs2"}, 32'(out_rs2), 32'(e.rs2));
                checkVal({tag, "_rd"}, 32'(out_rd), 32'(e.rd));
                checkVal({tag, "_aluSel"}, 32'(out_inst_ALU), 32'(e.alu));
            end
        end
    endtask

    // Drives one cycle of IF/ID inputs, checks id_stall, then checks the captured entry.
    task automatic applyStimulus(input string tag, input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic fl, input logic rdy,
                                 input logic rs, input logic expStall, input exp_t e);
        in_valid = v; in_instr = instr; in_pc = pc;
        flush = fl; ex_ready = rdy; rst = rs;
        #1;
        checkVal({tag, "_stall"}, 32'(id_stall), 32'(expStall));
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t zero;
        zero = mk(1'b0, C_NONE, 1'b1, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0);
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; ex_ready = 1'b1;

        applyStimulus("reset0", 1, I_ADD, 32'h40, 0, 1, 1, 0, zero);
        applyStimulus("reset1", 1, I_LW5, 32'h44, 0, 1, 1, 0, zero);

        applyStimulus("addi", 1, I_ADDI, 32'h100, 0, 1, 0, 0,
                      mk(1, C_IMM, 1, 32'h100, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 4'h0));
        applyStimulus("lui", 1, I_LUI, 32'h104, 0, 1, 0, 0,
                      mk(1, C_UPP, 1, 32'h104, 32'h12345000, 5'd8, 5'd3, 5'd2, 4'h5));
        applyStimulus("jal", 1, I_JAL, 32'h108, 0, 1, 0, 0,
                      mk(1, C_JAL, 1, 32'h108, 32'hFFFFFFFC, 5'd31, 5'd29, 5'd1, 4'hF));
        applyStimulus("beq", 1, I_BEQ, 32'h10C, 0, 1, 0, 0,
                      mk(1, C_BR, 1, 32'h10C, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 4'h8));
        applyStimulus("srai", 1, I_SRAI, 32'h110, 0, 1, 0, 0,
                      mk(1, C_IMM, 1, 32'h110, 32'h00000404, 5'd1, 5'd4, 5'd3, 4'hD));

        applyStimulus("lu_load", 1, I_LW5, 32'h114, 0, 1, 0, 0,
                      mk(1, C_LD, 1, 32'h114, 32'h0, 5'd1, 5'd0, 5'd5, 4'h2));
        applyStimulus("lu_bubble", 1, I_ADD, 32'h118, 0, 1, 0, 1, bubble());
        applyStimulus("lu_issue", 1, I_ADD, 32'h118, 0, 1, 0, 0,
                      mk(1, C_R, 1, 32'h118, 32'h0, 5'd5, 5'd2, 5'd6, 4'h0));

        applyStimulus("x0_load", 1, I_LW0, 32'h11C, 0, 1, 0, 0,
                      mk(1, C_LD, 1, 32'h11C, 32'h0, 5'd1, 5'd0, 5'd0, 4'h2));
        applyStimulus("x0_add", 1, I_ADD00, 32'h120, 0, 1, 0, 0,
                      mk(1, C_R, 1, 32'h120, 32'h0, 5'd0, 5'd0, 5'd6, 4'h0));
        applyStimulus("sw_load", 1, I_LW5, 32'h124, 0, 1, 0, 0,
                      mk(1, C_LD, 1, 32'h124, 32'h0, 5'd1, 5'd0, 5'd5, 4'h2));
        applyStimulus("sw_bubble", 1, I_SW, 32'h128, 0, 1, 0, 1, bubble());
        applyStimulus("sw_issue", 1, I_SW, 32'h128, 0, 1, 0, 0,
                      mk(1, C_ST, 1, 32'h128, 32'h0, 5'd5, 5'd7, 5'd0, 4'h2));

        applyStimulus("fl_load", 1, I_LW5, 32'h12C, 0, 1, 0, 0,
                      mk(1, C_LD, 1, 32'h12C, 32'h0, 5'd1, 5'd0, 5'd5, 4'h2));
        applyStimulus("fl_flush", 1, I_ADD, 32'h130, 1, 1, 0, 0, bubble());
        applyStimulus("fl_next", 1, I_ADDI, 32'h134, 0, 1, 0, 0,
                      mk(1, C_IMM, 1, 32'h134, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 4'h0));

        applyStimulus("bp_lui", 1, I_LUI, 32'h138, 0, 1, 0, 0,
                      mk(1, C_UPP, 1, 32'h138, 32'h12345000, 5'd8, 5'd3, 5'd2, 4'h5));
        for (int i = 0; i < 3; i++)
            applyStimulus("bp_hold", 1, I_ADDI, 32'h13C, 0, 0, 0, 1,
                          mk(1, C_UPP, 1, 32'h138, 32'h12345000, 5'd8, 5'd3, 5'd2, 4'h5));
        applyStimulus("bp_idle", 0, I_ADDI, 32'h13C, 0, 0, 0, 0,
                      mk(1, C_UPP, 1, 32'h138, 32'h12345000, 5'd8, 5'd3, 5'd2, 4'h5));
        applyStimulus("bp_release", 1, I_ADDI, 32'h13C, 0, 1, 0, 0,
                      mk(1, C_IMM, 1, 32'h13C, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 4'h0));
        applyStimulus("bp_after", 1, I_ADD00, 32'h140, 0, 1, 0, 0,
                      mk(1, C_R, 1, 32'h140, 32'h0, 5'd0, 5'd0, 5'd6, 4'h0));

        applyStimulus("rs_load", 1, I_LW5, 32'h144, 0, 1, 0, 0,
                      mk(1, C_LD, 1, 32'h144, 32'h0, 5'd1, 5'd0, 5'd5, 4'h2));
        in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h148; flush = 1'b0; ex_ready = 1'b1;
        #1;
        checkVal("rs_stall_pre", 32'(id_stall), 32'd1);
        applyStimulus("rs_reset", 1, I_ADD, 32'h148, 0, 1, 1, 0, zero);
        applyStimulus("rs_resume", 1, I_ADD, 32'h148, 0, 1, 0, 0,
                      mk(1, C_R, 1, 32'h148, 32'h0, 5'd5, 5'd2, 5'd6, 4'h0));

        applyStimulus("illegal", 1, I_ILL, 32'h14C, 0, 1, 0, 0,
                      mk(1, C_ILL, 1, 32'h14C, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0));
        applyStimulus("invalid_in", 0, I_ADDI, 32'h150, 0, 1, 0, 0, bubble());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
